// File: rtl/temporal_pkg.sv
// Shared types and constants for the temporal less-than-or-equal comparator array.
// Holds the per-channel FSM state encoding and the mode select values.
package temporal_pkg;

  typedef enum logic [1:0] {
    WAIT  = 2'd0,
    PASS  = 2'd1,
    BLOCK = 2'd2
  } chan_state_t;

  localparam logic MODE_LTE = 1'b0;
  localparam logic MODE_LT  = 1'b1;

  // A same-cycle a/b tie lets a through only in less-than-or-equal mode.
  function automatic logic tie_passes(input logic mode);
    return (mode == MODE_LTE);
  endfunction

endpackage

// File: rtl/temporal_lte_chan.sv
// One comparator channel: edge detection on a/b, first-arrival FSM and a
// fixed-length output pulse started when a wins the race within a gamma cycle.
module temporal_lte_chan
  import temporal_pkg::*;
#(
  parameter int PULSE_WIDTH = 8
) (
  input  logic aclk,
  input  logic grst,
  input  logic gamma_start,
  input  logic mode,
  input  logic a,
  input  logic b,
  output logic q
);

  localparam logic [7:0] PW_LOAD = 8'(PULSE_WIDTH);

  chan_state_t state_reg, state_next, state_cur;
  logic        prev_a_reg, prev_b_reg;
  logic [7:0]  cnt_reg, cnt_next;
  logic        q_reg, q_next;
  logic        rise_a, rise_b;

  always_ff @(posedge aclk or posedge grst) begin
    if (grst) begin
      state_reg  <= WAIT;
      prev_a_reg <= 1'b0;
      prev_b_reg <= 1'b0;
      cnt_reg    <= 8'd0;
      q_reg      <= 1'b0;
    end else begin
      state_reg  <= state_next;
      prev_a_reg <= a;
      prev_b_reg <= b;
      cnt_reg    <= cnt_next;
      q_reg      <= q_next;
    end
  end

  always_comb begin
    rise_a     = a & ~prev_a_reg;
    rise_b     = b & ~prev_b_reg;
    // gamma_start restarts the race this very cycle, so edges now are time 0.
    state_cur  = gamma_start ? WAIT : state_reg;
    state_next = state_cur;
    if (gamma_start)
      cnt_next = 8'd0;
    else if (cnt_reg != 8'd0)
      cnt_next = cnt_reg - 8'd1;
    else
      cnt_next = 8'd0;

    if (state_cur == WAIT) begin
      if (rise_a && (!rise_b || tie_passes(mode))) begin
        state_next = PASS;
        cnt_next   = PW_LOAD;
      end else if (rise_b) begin
        state_next = BLOCK;
      end
    end
    q_next = (cnt_next != 8'd0);
  end

  assign q = q_reg;

endmodule

// File: rtl/temporal_lte_array.sv
// Array of independent temporal comparator channels sharing a gamma-cycle
// strobe, plus the saturating gamma-cycle time counter.
module temporal_lte_array
  import temporal_pkg::*;
#(
  parameter int N_CH              = 4,
  parameter int GAMMA_CYCLE_WIDTH = 16,
  parameter int PULSE_WIDTH       = 8
) (
  input  logic                         aclk,
  input  logic                         grst,
  input  logic                         gamma_start,
  input  logic                         mode,
  input  logic [N_CH-1:0]              a,
  input  logic [N_CH-1:0]              b,
  output logic [N_CH-1:0]              q,
  output logic [GAMMA_CYCLE_WIDTH-1:0] gamma_cnt
);

  logic [GAMMA_CYCLE_WIDTH-1:0] gamma_cnt_reg, gamma_cnt_next;

  always_ff @(posedge aclk or posedge grst) begin
    if (grst)
      gamma_cnt_reg <= '0;
    else
      gamma_cnt_reg <= gamma_cnt_next;
  end

  always_comb begin
    if (gamma_start)
      gamma_cnt_next = '0;
    else if (&gamma_cnt_reg)
      gamma_cnt_next = gamma_cnt_reg;
    else
      gamma_cnt_next = gamma_cnt_reg + GAMMA_CYCLE_WIDTH'(1);
  end

  assign gamma_cnt = gamma_cnt_reg;

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_chan
      temporal_lte_chan #(
        .PULSE_WIDTH(PULSE_WIDTH)
      ) u_chan (
        .aclk       (aclk),
        .grst       (grst),
        .gamma_start(gamma_start),
        .mode       (mode),
        .a          (a[gi]),
        .b          (b[gi]),
        .q          (q[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_temporal_lte_array.sv
// Directed bench for temporal_lte_array: reset behaviour, race outcomes,
// pulse length/truncation, held lines, counter saturation and random orders.
module tb_temporal_lte_array;
  import temporal_pkg::*;

  localparam int N_CH = 4;
  localparam int GW   = 16;
  localparam int PW   = 8;
  localparam int NEV  = 99;

  logic            aclk;
  logic            grst;
  logic            gamma_start;
  logic            mode;
  logic [N_CH-1:0] a;
  logic [N_CH-1:0] b;
  logic [N_CH-1:0] q;
  logic [GW-1:0]   gamma_cnt;

  int n_assert;
  int n_fail;
  int at_t [N_CH];
  int bt_t [N_CH];

  temporal_lte_array #(
    .N_CH(N_CH), .GAMMA_CYCLE_WIDTH(GW), .PULSE_WIDTH(PW)
  ) dut (
    .aclk(aclk), .grst(grst), .gamma_start(gamma_start), .mode(mode),
    .a(a), .b(b), .q(q), .gamma_cnt(gamma_cnt)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One gamma cycle of len cycles; lines rise at at_t/bt_t and drop near the end.
  task automatic run_gamma(input logic m, input int len, input string tag);
    logic [N_CH-1:0] exp_q;
    logic            pass;
    $display("gamma %s mode=%0d a_t=%0d,%0d,%0d,%0d b_t=%0d,%0d,%0d,%0d", tag, m,
             at_t[0], at_t[1], at_t[2], at_t[3], bt_t[0], bt_t[1], bt_t[2], bt_t[3]);
    for (int c = 0; c < len; c++) begin
      gamma_start = (c == 0);
      mode        = m;
      for (int i = 0; i < N_CH; i++) begin
        a[i] = (c >= at_t[i]) && (c < len - 4);
        b[i] = (c >= bt_t[i]) && (c < len - 4);
      end
      tick();
      for (int i = 0; i < N_CH; i++) begin
        pass = (at_t[i] != NEV) &&
               ((bt_t[i] == NEV) || (at_t[i] < bt_t[i]) ||
                ((at_t[i] == bt_t[i]) && (m == MODE_LTE)));
        exp_q[i] = pass && (c + 1 >= at_t[i] + 1) && (c + 1 <= at_t[i] + PW);
      end
      chk({tag, "_q"}, 32'(q), 32'(exp_q));
      chk({tag, "_gcnt"}, 32'(gamma_cnt), 32'(c));
    end
  endtask

  initial begin
    n_assert    = 0;
    n_fail      = 0;
    grst        = 1'b1;
    gamma_start = 1'b0;
    mode        = MODE_LTE;
    a           = 4'b0010;
    b           = 4'b0000;

    // Reset state, then a line already high at release counts as a rise.
    tick();
    tick();
    chk("rst_q", 32'(q), 32'h0);
    chk("rst_gcnt", 32'(gamma_cnt), 32'h0);
    grst = 1'b0;
    tick();
    $display("release grst with a[1] high");
    chk("rel_q", 32'(q), 32'h2);
    chk("rel_gcnt", 32'(gamma_cnt), 32'h1);
    a = 4'b0000;
    tick();

    // a before b, b before a, ties under both modes.
    at_t = '{3, 4, 6, NEV};
    bt_t = '{5, 2, 6, NEV};
    run_gamma(MODE_LTE, 24, "dir_lte");
    run_gamma(MODE_LT, 24, "dir_lt");

    // Second a edge in the same gamma cycle is ignored; a[3] rises and is held.
    $display("gamma double_a");
    for (int c = 0; c < 31; c++) begin
      gamma_start = (c == 0);
      mode        = MODE_LTE;
      a           = '0;
      b           = '0;
      a[0]        = (c == 1) || (c == 20);
      a[3]        = (c >= 2);
      tick();
      chk("dbl_q0", 32'(q[0]), 32'((c + 1 >= 2) && (c + 1 <= 9)));
      chk("dbl_q3", 32'(q[3]), 32'((c + 1 >= 3) && (c + 1 <= 10)));
    end

    // gamma_start truncates a pulse; a[3] still held produces no new edge.
    $display("gamma truncate");
    for (int c = 0; c < 11; c++) begin
      gamma_start = (c == 0) || (c == 4);
      a[0]        = (c == 1);
      a[3]        = 1'b1;
      tick();
      chk("trn_q0", 32'(q[0]), 32'((c + 1 >= 2) && (c + 1 <= 4)));
      chk("trn_q3", 32'(q[3]), 32'h0);
    end
    a = '0;
    tick();

    // Random arrival orders per channel, checked against the timing model.
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < N_CH; i++) begin
        at_t[i] = ($urandom_range(0, 4) == 0) ? NEV : int'($urandom_range(1, 10));
        bt_t[i] = ($urandom_range(0, 4) == 0) ? NEV : int'($urandom_range(1, 10));
      end
      run_gamma(logic'($urandom_range(0, 1)), 24, "rnd");
    end

    // Asynchronous reset in the middle of a pulse.
    $display("async grst mid-pulse");
    gamma_start = 1'b1;
    a           = '0;
    tick();
    gamma_start = 1'b0;
    a[0]        = 1'b1;
    tick();
    tick();
    chk("pre_arst_q", 32'(q), 32'h1);
    #2;
    grst = 1'b1;
    #1;
    chk("arst_q", 32'(q), 32'h0);
    chk("arst_gcnt", 32'(gamma_cnt), 32'h0);
    a = '0;
    tick();
    grst = 1'b0;
    tick();

    // Long run without gamma_start: counter saturates and does not wrap.
    $display("gamma saturation run");
    for (int c = 0; c < 70000; c++) begin
      gamma_start = (c == 0);
      tick();
      if (c + 1 == 65535 || c + 1 == 65536 || c + 1 == 70000)
        chk("sat_gcnt", 32'(gamma_cnt), (c < 65535) ? 32'(c) : 32'd65535);
    end
    chk("sat_q", 32'(q), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
